// File: rtl/imm_pkg.sv
// Shared types for the immediate generator: format select, entry layout, sign-extension helper.
// Latency: none (declarations only).
// Backpressure: not applicable.
package imm_pkg;

    localparam int INSTR_WIDTH   = 32;
    // Entries are stored at the widest legal output width; narrower builds use the low bits.
    localparam int IMM_MAX_WIDTH = 64;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_src_t;

    typedef struct packed {
        logic [IMM_MAX_WIDTH-1:0] imm;
        logic                     err;
    } imm_entry_t;

    // Sign-extend a 32-bit immediate from bit 31 up to the widest output width.
    function automatic logic [IMM_MAX_WIDTH-1:0] sext_imm(input logic [INSTR_WIDTH-1:0] v);
        return {{(IMM_MAX_WIDTH-INSTR_WIDTH){v[INSTR_WIDTH-1]}}, v};
    endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational RISC-V immediate decode (I/S/B/U/J) with illegal-format flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller decides when the result is captured.
module imm_decode
    import imm_pkg::*;
(
    input  logic [INSTR_WIDTH-1:0] instr,
    input  logic [2:0]             imm_src,
    output imm_entry_t             entry
);

    logic [INSTR_WIDTH-1:0] imm32;
    logic                   err;

    // Assemble the 32-bit immediate for the selected format; unknown formats give zero plus err.
    always_comb begin
        imm32 = '0;
        err   = 1'b0;
        case (imm_src)
            IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm32 = {instr[31:12], 12'b0};
            IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: begin
                imm32 = '0;
                err   = 1'b1;
            end
        endcase
    end

    assign entry.imm = sext_imm(imm32);
    assign entry.err = err;

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode into main register M, with one-entry skid register K.
// Latency: 1 cycle from input transfer to out_valid when M is empty or draining.
// Backpressure: in_ready is registered (= K empty next cycle); no entry is dropped under out_ready=0.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTR_WIDTH-1:0] instr,
    input  logic [2:0]             imm_src,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  imm_op,
    output logic                   imm_err,
    output logic [CNT_WIDTH-1:0]   xfer_count
);

    imm_entry_t           dec_entry;
    imm_entry_t           m_q, m_d;
    imm_entry_t           k_q, k_d;
    logic                 m_vld, m_vld_d;
    logic                 k_vld, k_vld_d;
    logic                 in_rdy_q;
    logic                 in_xfer;
    logic                 out_xfer;
    logic [CNT_WIDTH-1:0] cnt_q;

    imm_decode u_decode (
        .instr   (instr),
        .imm_src (imm_src),
        .entry   (dec_entry)
    );

    assign in_xfer  = in_valid && in_rdy_q;
    assign out_xfer = m_vld && out_ready;

    // Skid next-state: refill M from K first, otherwise from the decoder; park in K only when M is stuck.
    always_comb begin
        m_d     = m_q;
        k_d     = k_q;
        m_vld_d = m_vld;
        k_vld_d = k_vld;
        if (out_xfer) begin
            if (k_vld) begin
                // in_ready is low whenever K is full, so no input can collide here.
                m_d     = k_q;
                k_vld_d = 1'b0;
            end else if (in_xfer) begin
                m_d = dec_entry;
            end else begin
                m_vld_d = 1'b0;
            end
        end else if (in_xfer) begin
            if (m_vld) begin
                k_d     = dec_entry;
                k_vld_d = 1'b1;
            end else begin
                m_d     = dec_entry;
                m_vld_d = 1'b1;
            end
        end
    end

    // State registers; reset empties both entries and holds in_ready low until the first edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q      <= '0;
            k_q      <= '0;
            m_vld    <= 1'b0;
            k_vld    <= 1'b0;
            in_rdy_q <= 1'b0;
        end else begin
            m_q      <= m_d;
            k_q      <= k_d;
            m_vld    <= m_vld_d;
            k_vld    <= k_vld_d;
            in_rdy_q <= !k_vld_d;
        end
    end

    // Completed output transfers, wrapping naturally at the counter width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (out_xfer) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    assign in_ready   = in_rdy_q;
    assign out_valid  = m_vld;
    assign imm_op     = m_q.imm[DATA_WIDTH-1:0];
    assign imm_err    = m_q.err;
    assign xfer_count = cnt_q;

    // Narrow builds leave the upper stored bits unread; they only ever carry sign copies.
    if (DATA_WIDTH < IMM_MAX_WIDTH) begin : g_narrow
        logic unused_hi;
        assign unused_hi = ^{m_q.imm[IMM_MAX_WIDTH-1:DATA_WIDTH], k_q.imm[IMM_MAX_WIDTH-1:DATA_WIDTH]};
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench: a 32-bit/16-bit-counter and a 64-bit/4-bit-counter instance share one stimulus.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic [2:0]  imm_src;

    logic        in_ready_a, out_valid_a, imm_err_a;
    logic [31:0] imm_op_a;
    logic [15:0] xfer_count_a;

    logic        in_ready_b, out_valid_b, imm_err_b;
    logic [63:0] imm_op_b;
    logic [3:0]  xfer_count_b;

    int checks  = 0;
    int errors  = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .instr(instr), .imm_src(imm_src), .out_valid(out_valid_a), .out_ready(out_ready),
        .imm_op(imm_op_a), .imm_err(imm_err_a), .xfer_count(xfer_count_a)
    );

    imm_gen_pipe #(.DATA_WIDTH(64), .CNT_WIDTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .instr(instr), .imm_src(imm_src), .out_valid(out_valid_b), .out_ready(out_ready),
        .imm_op(imm_op_b), .imm_err(imm_err_b), .xfer_count(xfer_count_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic vld, input logic [63:0] imm, input logic err);
        chk({tag, "/vld32"}, 64'(out_valid_a), 64'(vld));
        chk({tag, "/imm32"}, 64'(imm_op_a),    64'(imm[31:0]));
        chk({tag, "/err32"}, 64'(imm_err_a),   64'(err));
        chk({tag, "/vld64"}, 64'(out_valid_b), 64'(vld));
        chk({tag, "/imm64"}, imm_op_b,         imm);
        chk({tag, "/err64"}, 64'(imm_err_b),   64'(err));
    endtask

    task automatic chk_rdy(input string tag, input logic rdy);
        chk({tag, "/rdy32"}, 64'(in_ready_a), 64'(rdy));
        chk({tag, "/rdy64"}, 64'(in_ready_b), 64'(rdy));
    endtask

    task automatic chk_cnt(input string tag);
        logic [15:0] e16;
        logic [3:0]  e4;
        e16 = 16'(exp_cnt);
        e4  = 4'(exp_cnt);
        chk({tag, "/cnt16"}, 64'(xfer_count_a), 64'(e16));
        chk({tag, "/cnt4"},  64'(xfer_count_b), 64'(e4));
    endtask

    // One entry through an idle pipe with out_ready high; inputs go X once the handshake is done.
    task automatic send_one(input string tag, input logic [31:0] ins, input logic [2:0] src,
                            input logic [63:0] imm, input logic err);
        in_valid  = 1'b1;
        instr     = ins;
        imm_src   = src;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        instr    = 'x;
        imm_src  = 'x;
        chk_out(tag, 1'b1, imm, err);
        tick();
        exp_cnt++;
        chk_out({tag, "_held"}, 1'b0, imm, err);
        chk_cnt(tag);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        instr     = '0;
        imm_src   = '0;
        #1;
        chk_out("reset", 1'b0, 64'h0, 1'b0);
        chk_rdy("reset", 1'b0);
        chk_cnt("reset");
        tick();
        tick();
        chk_rdy("reset_held", 1'b0);
        rst_n = 1'b1;
        #2;
        chk_rdy("post_release_pre_edge", 1'b0);
        tick();
        chk_rdy("first_edge", 1'b1);

        // Every format, both signs where it matters.
        send_one("i_neg",  32'hFFF00093, 3'd0, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        send_one("i_pos",  32'h7FF00013, 3'd0, 64'h00000000000007FF, 1'b0);
        send_one("s_neg",  32'h80000F80, 3'd1, 64'hFFFFFFFFFFFFF81F, 1'b0);
        send_one("u_neg",  32'h80000537, 3'd3, 64'hFFFFFFFF80000000, 1'b0);
        send_one("u_pos",  32'h12345037, 3'd3, 64'h0000000012345000, 1'b0);
        send_one("b_m4",   32'hFE000EE3, 3'd2, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        send_one("b_b11",  32'hFE000E63, 3'd2, 64'hFFFFFFFFFFFFF7FC, 1'b0);
        send_one("j_neg",  32'h8000006F, 3'd4, 64'hFFFFFFFFFFF00000, 1'b0);
        send_one("ill6",   32'hFFFFFFFF, 3'd6, 64'h0, 1'b1);
        send_one("ill7",   32'h12345678, 3'd7, 64'h0, 1'b1);
        send_one("ill5",   32'hFFF00093, 3'd5, 64'h0, 1'b1);

        // Back-pressure: A and B are taken, C waits while out_ready is low.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'hFFF00093;
        imm_src   = 3'd0;
        tick();
        chk_rdy("bp_a", 1'b1);
        chk_out("bp_a", 1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        instr   = 32'h12345037;
        imm_src = 3'd3;
        tick();
        chk_rdy("bp_b", 1'b0);
        chk_out("bp_b_stable", 1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        instr   = 32'h8000006F;
        imm_src = 3'd4;
        tick();
        tick();
        chk_rdy("bp_c_wait", 1'b0);
        chk_out("bp_c_wait", 1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        out_ready = 1'b1;
        tick();
        exp_cnt++;
        chk_rdy("bp_rel_b", 1'b1);
        chk_out("bp_rel_b", 1'b1, 64'h0000000012345000, 1'b0);
        tick();
        exp_cnt++;
        in_valid = 1'b0;
        chk_out("bp_rel_c", 1'b1, 64'hFFFFFFFFFFF00000, 1'b0);
        tick();
        exp_cnt++;
        chk_out("bp_drained", 1'b0, 64'hFFFFFFFFFFF00000, 1'b0);
        chk_cnt("bp_count");

        // Mid-operation reset with both entries occupied.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'h7FF00013;
        imm_src   = 3'd0;
        tick();
        instr = 32'h80000537;
        imm_src = 3'd3;
        tick();
        in_valid = 1'b0;
        chk_rdy("full_pre_rst", 1'b0);
        chk_out("full_pre_rst", 1'b1, 64'h00000000000007FF, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        chk_rdy("async_rst", 1'b0);
        chk_out("async_rst", 1'b0, 64'h0, 1'b0);
        chk_cnt("async_rst");
        #1;
        rst_n = 1'b1;
        tick();
        chk_rdy("rst_release", 1'b1);
        chk_out("no_stale", 1'b0, 64'h0, 1'b0);
        out_ready = 1'b1;
        tick();
        tick();
        chk_out("no_stale_later", 1'b0, 64'h0, 1'b0);
        chk_cnt("no_stale_later");

        // Streaming: immediate of entry i is i; counter wraps in the 4-bit instance.
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            instr    = {12'(i), 20'h00013};
            imm_src  = 3'd0;
            tick();
            chk_rdy($sformatf("stream%0d", i), 1'b1);
            chk_out($sformatf("stream%0d", i), 1'b1, 64'(i), 1'b0);
            chk_cnt($sformatf("stream%0d", i));
            exp_cnt++;
        end
        in_valid = 1'b0;
        tick();
        chk_out("stream_end", 1'b0, 64'd19, 1'b0);
        chk_cnt("stream_end");
        chk("stream_wrap4", 64'(xfer_count_b), 64'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
